// File: rtl/hsv_ctrl_pkg.sv
// hsv_ctrl_pkg
// Shared definitions for the RGB-to-HSV arbiter slice:
//   - PIPE_LAT_DEFAULT : default latency of the external RGB->HSV pipe
//   - state_e          : arbiter controller states
//   - tag_t            : side-band tag that travels alongside each pixel
package hsv_ctrl_pkg;

  localparam int PIPE_LAT_DEFAULT = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One tag per issued pipe slot; valid=0 marks an empty slot.
  typedef struct packed {
    logic valid;
    logic src;
    logic sof;
    logic eol;
  } tag_t;

endpackage

// File: rtl/hsv_tag_delay.sv
// hsv_tag_delay
// Fixed-depth shift line that carries one tag per clock alongside the
// external pipe, so the result side knows which source (and which frame
// flags) each pipe output belongs to.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset, empties every stage
//   push_tag : tag entering the line this cycle
//   exit_tag : tag that entered DEPTH cycles ago
module hsv_tag_delay
  import hsv_ctrl_pkg::*;
#(
  parameter int  DEPTH    = PIPE_LAT_DEFAULT + 1,
  parameter type tag_type = tag_t
) (
  input  logic    clk,
  input  logic    rst,
  input  tag_type push_tag,
  output tag_type exit_tag
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    tag_type q_reg;

    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) q_reg <= '0;
        else     q_reg <= push_tag;
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) q_reg <= '0;
        else     q_reg <= g_stage[gi-1].q_reg;
      end
    end
  end

  assign exit_tag = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/rgb_hsv_arbiter.sv
// rgb_hsv_arbiter
// Arbitrates two pixel sources onto one external fixed-latency RGB->HSV
// pipe and routes each pipe result back to the sink of its source.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   enable              : allows IDLE->RUN; dropping it in RUN starts a drain
//   flush_req           : pulse, stop accepting and drain (RUN only)
//   s_valid/s_ready     : per-source handshake (2 sources)
//   s_rgb               : {src1 {r,g,b}, src0 {r,g,b}}
//   s_sof/s_eol         : per-source frame flags
//   p_r/p_g/p_b         : pixel issued to the pipe
//   p_h/p_s/p_v         : pipe results
//   m_valid             : per-sink result valid, at most one-hot
//   m_h/m_s/m_v         : shared result bus, held between beats
//   m_sof/m_eol         : frame flags of the current result beat
//   busy                : high in RUN and DRAIN
//   flush_done          : single-cycle pulse when the drain completes
module rgb_hsv_arbiter
  import hsv_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEFAULT,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        flush_req,
  input  logic [1:0]  s_valid,
  output logic [1:0]  s_ready,
  input  logic [47:0] s_rgb,
  input  logic [1:0]  s_sof,
  input  logic [1:0]  s_eol,
  output logic [7:0]  p_r,
  output logic [7:0]  p_g,
  output logic [7:0]  p_b,
  input  logic [8:0]  p_h,
  input  logic [10:0] p_s,
  input  logic [7:0]  p_v,
  output logic [1:0]  m_valid,
  output logic [8:0]  m_h,
  output logic [10:0] m_s,
  output logic [7:0]  m_v,
  output logic        m_sof,
  output logic        m_eol,
  output logic        busy,
  output logic        flush_done
);

  state_e           state_reg, state_next;
  logic             rr_ptr_reg;
  logic [CNT_W-1:0] inflight_reg;
  logic             grant_src;
  logic             handshake;
  logic [23:0]      grant_rgb;
  tag_t             push_tag, exit_tag;

  // Grant: the only valid source, or the pointed-to one when both are valid.
  always_comb begin
    grant_src = (s_valid == 2'b11) ? rr_ptr_reg : s_valid[1];
    s_ready   = 2'b00;
    if (state_reg == ST_RUN && s_valid != 2'b00) s_ready[grant_src] = 1'b1;
  end

  assign handshake = |(s_valid & s_ready);
  assign grant_rgb = grant_src ? s_rgb[47:24] : s_rgb[23:0];

  always_comb begin
    push_tag       = '0;
    push_tag.valid = handshake;
    push_tag.src   = grant_src;
    push_tag.sof   = s_sof[grant_src];
    push_tag.eol   = s_eol[grant_src];
  end

  // The tag must line up with the pipe output one cycle after the pipe
  // delivers it, because the issue register adds a cycle in front of the pipe.
  hsv_tag_delay #(
    .DEPTH    (PIPE_LAT + 1),
    .tag_type (tag_t)
  ) u_tag_delay (
    .clk      (clk),
    .rst      (rst),
    .push_tag (push_tag),
    .exit_tag (exit_tag)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (enable) state_next = ST_RUN;
      ST_RUN:   if (flush_req || !enable) state_next = ST_DRAIN;
      ST_DRAIN: if (inflight_reg == '0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (handshake) rr_ptr_reg <= ~rr_ptr_reg;
    end
  end

  // Simultaneous issue and exit leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg <= '0;
    end else begin
      case ({handshake, exit_tag.valid})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_r <= '0;
      p_g <= '0;
      p_b <= '0;
    end else if (handshake) begin
      {p_r, p_g, p_b} <= grant_rgb;
    end
  end

  // Result data is held between beats; the frame flags only mark live beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 2'b00;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_h     <= '0;
      m_s     <= '0;
      m_v     <= '0;
    end else begin
      m_valid <= exit_tag.valid ? (exit_tag.src ? 2'b10 : 2'b01) : 2'b00;
      m_sof   <= exit_tag.valid & exit_tag.sof;
      m_eol   <= exit_tag.valid & exit_tag.eol;
      if (exit_tag.valid) begin
        m_h <= p_h;
        m_s <= p_s;
        m_v <= p_v;
      end
    end
  end

  assign busy       = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign flush_done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_rgb_hsv_arbiter.sv
`timescale 1ns/1ps
module tb_rgb_hsv_arbiter;
  import hsv_ctrl_pkg::*;

  localparam int PIPE_LAT = 9;
  // Edges from the handshake edge to the edge that registers the result.
  localparam int RES_LAT  = PIPE_LAT + 1;

  localparam int MS_IDLE  = 0;
  localparam int MS_RUN   = 1;
  localparam int MS_DRAIN = 2;
  localparam int MS_DONE  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        flush_req = 1'b0;
  logic [1:0]  s_valid = 2'b00;
  logic [1:0]  s_ready;
  logic [47:0] s_rgb = '0;
  logic [1:0]  s_sof = 2'b00;
  logic [1:0]  s_eol = 2'b00;
  logic [7:0]  p_r, p_g, p_b;
  logic [8:0]  p_h;
  logic [10:0] p_s;
  logic [7:0]  p_v;
  logic [1:0]  m_valid;
  logic [8:0]  m_h;
  logic [10:0] m_s;
  logic [7:0]  m_v;
  logic        m_sof, m_eol, busy, flush_done;

  always #5 clk = ~clk;

  rgb_hsv_arbiter #(.PIPE_LAT(PIPE_LAT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush_req(flush_req),
    .s_valid(s_valid), .s_ready(s_ready), .s_rgb(s_rgb),
    .s_sof(s_sof), .s_eol(s_eol),
    .p_r(p_r), .p_g(p_g), .p_b(p_b),
    .p_h(p_h), .p_s(p_s), .p_v(p_v),
    .m_valid(m_valid), .m_h(m_h), .m_s(m_s), .m_v(m_v),
    .m_sof(m_sof), .m_eol(m_eol), .busy(busy), .flush_done(flush_done)
  );

  // Stand-in for the external pipe: an arbitrary but distinctive mapping.
  function automatic logic [8:0] f_h(logic [23:0] px);
    return {px[16], px[15:8]};
  endfunction
  function automatic logic [10:0] f_s(logic [23:0] px);
    return {3'b101, px[7:0]};
  endfunction
  function automatic logic [7:0] f_v(logic [23:0] px);
    return px[23:16] ^ px[7:0];
  endfunction

  logic [23:0] hist [PIPE_LAT] = '{default: '0};
  always @(posedge clk) begin
    hist[0] <= {p_r, p_g, p_b};
    for (int i = 1; i < PIPE_LAT; i++) hist[i] <= hist[i-1];
  end
  assign p_h = f_h(hist[PIPE_LAT-1]);
  assign p_s = f_s(hist[PIPE_LAT-1]);
  assign p_v = f_v(hist[PIPE_LAT-1]);

  // ---------------- behavioural model ----------------
  typedef struct {
    int          exit_edge;
    logic        src;
    logic        sof;
    logic        eol;
    logic [23:0] px;
  } pend_t;

  pend_t       pend[$];
  int          cyc = 0;
  int          mst = MS_IDLE;
  logic        mptr = 1'b0;
  logic [23:0] e_p = '0;
  logic [1:0]  e_mv = '0;
  logic [8:0]  e_h = '0;
  logic [10:0] e_s = '0;
  logic [7:0]  e_v = '0;
  logic        e_sof = 1'b0, e_eol = 1'b0;

  int checks = 0;
  int errors = 0;
  int mv_beats = 0, fd_pulses = 0, sof_beats = 0, eol_beats = 0;
  int last_mv_cyc = 0, last_fd_cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_ready(int st, logic ptr, logic [1:0] v);
    if (st != MS_RUN || v == 2'b00) return 2'b00;
    if (v == 2'b11) return ptr ? 2'b10 : 2'b01;
    return v;
  endfunction

  task automatic model_edge();
    int         cnt;
    logic [1:0] rdy;
    logic       g;
    pend_t      t;
    if (rst) begin
      mst = MS_IDLE; mptr = 1'b0; pend.delete();
      e_p = '0; e_mv = '0; e_h = '0; e_s = '0; e_v = '0; e_sof = 1'b0; e_eol = 1'b0;
      return;
    end
    cnt   = pend.size();
    rdy   = exp_ready(mst, mptr, s_valid);
    e_mv  = 2'b00;
    e_sof = 1'b0;
    e_eol = 1'b0;
    if (pend.size() > 0 && pend[0].exit_edge == cyc) begin
      e_mv  = pend[0].src ? 2'b10 : 2'b01;
      e_sof = pend[0].sof;
      e_eol = pend[0].eol;
      e_h   = f_h(pend[0].px);
      e_s   = f_s(pend[0].px);
      e_v   = f_v(pend[0].px);
      void'(pend.pop_front());
    end
    if (rdy != 2'b00) begin
      g           = rdy[1];
      t.exit_edge = cyc + RES_LAT;
      t.src       = g;
      t.sof       = s_sof[g];
      t.eol       = s_eol[g];
      t.px        = g ? s_rgb[47:24] : s_rgb[23:0];
      pend.push_back(t);
      e_p  = t.px;
      mptr = !mptr;
    end
    case (mst)
      MS_IDLE:  if (enable) mst = MS_RUN;
      MS_RUN:   if (flush_req || !enable) mst = MS_DRAIN;
      MS_DRAIN: if (cnt == 0) mst = MS_DONE;
      default:  mst = MS_IDLE;
    endcase
  endtask

  task automatic compare_all();
    chk("s_ready",    32'(s_ready), 32'(exp_ready(mst, mptr, s_valid)));
    chk("busy",       32'(busy), 32'(mst == MS_RUN || mst == MS_DRAIN));
    chk("flush_done", 32'(flush_done), 32'(mst == MS_DONE));
    chk("p_rgb",      32'({p_r, p_g, p_b}), 32'(e_p));
    chk("m_valid",    32'(m_valid), 32'(e_mv));
    chk("m_sof",      32'(m_sof), 32'(e_sof));
    chk("m_eol",      32'(m_eol), 32'(e_eol));
    chk("m_h",        32'(m_h), 32'(e_h));
    chk("m_s",        32'(m_s), 32'(e_s));
    chk("m_v",        32'(m_v), 32'(e_v));
    chk("inflight",   32'(dut.inflight_reg), 32'(pend.size()));
    chk("inflight_no_wrap", 32'(int'(dut.inflight_reg) <= PIPE_LAT + 1), 1);
    if (m_valid != 2'b00) begin
      mv_beats++;
      last_mv_cyc = cyc;
      $display("RES cyc=%0d m_valid=%b h=%0h s=%0h v=%0h sof=%0b eol=%0b",
               cyc, m_valid, m_h, m_s, m_v, m_sof, m_eol);
    end
    if (flush_done) begin fd_pulses++; last_fd_cyc = cyc; end
    if (m_sof) sof_beats++;
    if (m_eol) eol_beats++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      model_edge();
      @(negedge clk);
      compare_all();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; flush_req = 1'b0; s_valid = 2'b00;
    s_sof = 2'b00; s_eol = 2'b00;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic at_cycle(int t);
    int guard = 0;
    @(negedge clk);
    while (cyc < t && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("at_cycle", 32'(cyc), 32'(t));
  endtask

  initial begin
    int hs_edge, first, mv0, fd0, sof0, eol0;
    logic [23:0] px0, px1;

    // Reset values
    tick(); tick(); rst = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_p_rgb", 32'({p_r, p_g, p_b}), 0);
    chk("rst_m_hsv", 32'({m_h, m_s, m_v} == '0), 1);
    chk("rst_flush_done", 32'(flush_done), 0);
    s_valid = 2'b01; #1;
    chk("idle_s_ready", 32'(s_ready), 0);
    s_valid = 2'b00;

    // Single pixel from source 0
    enable = 1'b1; tick();
    s_valid = 2'b01; s_rgb = {24'h000000, 24'hFF0000}; hs_edge = cyc + 1;
    tick(); s_valid = 2'b00;
    at_cycle(hs_edge);
    chk("single_p_r", 32'(p_r), 'hFF);
    chk("single_p_gb", 32'({p_g, p_b}), 0);
    at_cycle(hs_edge + RES_LAT - 1);
    chk("single_early", 32'(m_valid), 0);
    at_cycle(hs_edge + RES_LAT);
    chk("single_m_valid", 32'(m_valid), 'h1);
    chk("single_m_h", 32'(m_h), 'h100);
    chk("single_m_s", 32'(m_s), 'h500);
    chk("single_m_v", 32'(m_v), 'hFF);

    // Both sources valid for 8 cycles: alternating grants from source 0
    tick(); do_reset(); enable = 1'b1; tick();
    first = cyc + 1;
    for (int k = 0; k < 8; k++) begin
      px0 = 24'h100000 | 24'(k);
      px1 = 24'h2A0000 | 24'(k * 3);
      s_valid = 2'b11; s_rgb = {px1, px0}; #1;
      chk("rr_grant", 32'(s_ready), (k % 2 == 1) ? 'h2 : 'h1);
      tick();
    end
    s_valid = 2'b00;
    // One source only: granted regardless of pointer
    s_valid = 2'b10; s_rgb = {24'h0BCDEF, 24'h0}; #1;
    chk("lone_src1", 32'(s_ready), 'h2);
    tick(); s_valid = 2'b00;
    at_cycle(first + RES_LAT);
    chk("rr_first_sink", 32'(m_valid), 'h1);
    at_cycle(first + RES_LAT + 1);
    chk("rr_second_sink", 32'(m_valid), 'h2);

    // Flush on the 4th handshake
    tick(); do_reset(); enable = 1'b1; tick();
    mv0 = mv_beats; fd0 = fd_pulses;
    for (int k = 0; k < 4; k++) begin
      s_valid = 2'b01; s_rgb = {24'h0, 24'h300000 | 24'(k)}; flush_req = (k == 3);
      tick();
    end
    flush_req = 1'b0; enable = 1'b0; #1;
    hs_edge = cyc;
    chk("flush_s_ready", 32'(s_ready), 0);
    at_cycle(hs_edge + RES_LAT + 3);
    chk("flush_results", 32'(mv_beats - mv0), 4);
    chk("flush_pulses", 32'(fd_pulses - fd0), 1);
    chk("flush_last_result", 32'(last_mv_cyc), 32'(hs_edge + RES_LAT));
    chk("flush_done_cyc", 32'(last_fd_cyc), 32'(hs_edge + RES_LAT + 1));
    tick(); s_valid = 2'b00;

    // flush_req outside RUN is ignored
    flush_req = 1'b1; tick(); flush_req = 1'b0; #1;
    chk("idle_flush_busy", 32'(busy), 0);
    tick();
    chk("idle_flush_done", 32'(flush_done), 0);

    // sof/eol alignment on a 640-pixel line from source 1
    tick(); do_reset(); enable = 1'b1; tick();
    sof0 = sof_beats; eol0 = eol_beats;
    for (int k = 0; k < 640; k++) begin
      s_valid = 2'b10;
      s_rgb   = {24'(k * 40503), 24'h0};
      s_sof   = {1'(k == 0), 1'b1};
      s_eol   = {1'(k == 639), 1'b1};
      tick();
    end
    s_valid = 2'b00; s_sof = 2'b00; s_eol = 2'b00;
    repeat (RES_LAT + 3) tick();
    chk("line_sof_beats", 32'(sof_beats - sof0), 1);
    chk("line_eol_beats", 32'(eol_beats - eol0), 1);

    // Reset with 5 pixels in flight
    tick(); do_reset(); enable = 1'b1; tick();
    for (int k = 0; k < 5; k++) begin
      s_valid = 2'b01; s_rgb = {24'h0, 24'h500000 | 24'(k)};
      tick();
    end
    s_valid = 2'b00;
    chk("pre_reset_inflight", 32'(dut.inflight_reg), 5);
    rst = 1'b1; enable = 1'b0; tick(); rst = 1'b0;
    mv0 = mv_beats;
    repeat (13) tick();
    chk("post_reset_results", 32'(mv_beats - mv0), 0);
    chk("post_reset_state", 32'(dut.state_reg), 32'(ST_IDLE));
    chk("post_reset_inflight", 32'(dut.inflight_reg), 0);

    // enable dropped with 3 in flight
    tick(); do_reset(); enable = 1'b1; tick();
    mv0 = mv_beats; fd0 = fd_pulses;
    for (int k = 0; k < 3; k++) begin
      s_valid = (k == 1) ? 2'b10 : 2'b01;
      s_rgb   = {24'h600000 | 24'(k), 24'h700000 | 24'(k)};
      tick();
    end
    s_valid = 2'b00; enable = 1'b0;
    tick(); #1;
    chk("drop_busy_drain", 32'(busy), 1);
    repeat (RES_LAT + 4) tick();
    chk("drop_results", 32'(mv_beats - mv0), 3);
    chk("drop_pulses", 32'(fd_pulses - fd0), 1);
    chk("drop_state", 32'(dut.state_reg), 32'(ST_IDLE));

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
